// File: rtl/envase_pkg.sv
// Shared definitions for the wine bottling station sequencer.
//   - estado_e      : sequencer state type with its fixed 3-bit display encoding
//   - *Def          : default timeout, cap length, box size and batch size
//   - contagem_t    : 4-bit type for the bottle and box counts
//   - TmrWidth      : width of the shared fill/cap down-counter
package envase_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StEsteira = 3'd1,
    StEnche   = 3'd2,
    StVeda    = 3'd3,
    StConta   = 3'd4,
    StCaixa   = 3'd5,
    StLote    = 3'd6,
    StFalha   = 3'd7
  } estado_e;

  localparam int unsigned FillTimeoutDef   = 50;
  localparam int unsigned CapCyclesDef     = 4;
  localparam int unsigned BottlesPerBoxDef = 12;
  localparam int unsigned BoxesPerBatchDef = 10;

  localparam int unsigned TmrWidth = 8;

  typedef logic [3:0] contagem_t;

endpackage

// File: rtl/temporizador_envase.sv
// Loadable down-counter with clear and a done flag. Shared by the fill
// timeout and the capper hold time.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset
//   clear_i    : force count to zero (highest priority after reset)
//   load_i     : load load_val_i
//   load_val_i : value to load
//   en_i       : decrement while nonzero
//   done_o     : count is zero
module temporizador_envase #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [Width-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/controle_envase.sv
// Sequencer for one wine bottling station: advance conveyor, fill until the
// level sensor trips, cap, count bottles into boxes and boxes into a batch.
// All outputs are registered; ESTADO is the state register itself.
//
// Ports:
//   CLOCK, RESET (sync, active-high)
//   START, STOP, SENSOR_GARRAFA, SENSOR_NIVEL, ACK_LOTE : inputs
//   MOTOR, VALVULA, VEDADOR        : actuators (mutually exclusive)
//   PULSO_DUZIA                    : one-cycle pulse per completed box
//   LOTE_CHEIO, ALARME             : batch full / fill fault flags
//   GARRAFAS, DUZIAS, ESTADO       : counts and state for the display
//   REJEITA, REJEITADOS            : only with DESCARTE_EN
//
// Build option DESCARTE_EN: a fill timeout rejects the bottle (one-cycle
// FALHA, REJEITA pulse, saturating REJEITADOS count) instead of waiting
// for ACK_LOTE.
module controle_envase
  import envase_pkg::*;
#(
  parameter int unsigned FILL_TIMEOUT    = FillTimeoutDef,
  parameter int unsigned CAP_CYCLES      = CapCyclesDef,
  parameter int unsigned BOTTLES_PER_BOX = BottlesPerBoxDef,
  parameter int unsigned BOXES_PER_BATCH = BoxesPerBatchDef
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic       SENSOR_GARRAFA,
  input  logic       SENSOR_NIVEL,
  input  logic       ACK_LOTE,
  output logic       MOTOR,
  output logic       VALVULA,
  output logic       VEDADOR,
  output logic       PULSO_DUZIA,
  output logic       LOTE_CHEIO,
  output logic       ALARME,
  output logic [3:0] GARRAFAS,
  output logic [3:0] DUZIAS,
  output logic [2:0] ESTADO
`ifdef DESCARTE_EN
  ,
  output logic       REJEITA,
  output logic [7:0] REJEITADOS
`endif
);

  localparam contagem_t LastBottle = contagem_t'(BOTTLES_PER_BOX - 1);
  localparam contagem_t BatchBoxes = contagem_t'(BOXES_PER_BATCH);
  localparam logic [TmrWidth-1:0] FillLoad = TmrWidth'(FILL_TIMEOUT - 1);
  localparam logic [TmrWidth-1:0] CapLoad  = TmrWidth'(CAP_CYCLES - 1);

  estado_e   state_d, state_q;
  contagem_t garrafas_d, garrafas_q;
  contagem_t duzias_d, duzias_q;
  logic      motor_d, motor_q;
  logic      valvula_d, valvula_q;
  logic      vedador_d, vedador_q;
  logic      pulso_d, pulso_q;
  logic      lote_d, lote_q;
  logic      alarme_d, alarme_q;

  logic                tmr_clear, tmr_load, tmr_done;
  logic [TmrWidth-1:0] tmr_val;

`ifdef DESCARTE_EN
  logic       rejeita_d, rejeita_q;
  logic [7:0] rejeitados_d, rejeitados_q;
`endif

  temporizador_envase #(
    .Width(TmrWidth)
  ) u_tmr (
    .clk_i      (CLOCK),
    .rst_i      (RESET),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (1'b1),
    .done_o     (tmr_done)
  );

  // Next-state and counter logic.
  always_comb begin
    state_d    = state_q;
    garrafas_d = garrafas_q;
    duzias_d   = duzias_q;
    unique case (state_q)
      StIdle: begin
        if (START && !STOP) state_d = StEsteira;
      end
      StEsteira: begin
        // STOP wins over an arriving bottle: no new bottle is started.
        if (STOP) begin
          state_d = StIdle;
        end else if (SENSOR_GARRAFA) begin
          state_d = StEnche;
        end
      end
      StEnche: begin
        // Level sensor has priority over a timeout in the same cycle.
        if (SENSOR_NIVEL) begin
          state_d = StVeda;
        end else if (tmr_done) begin
          state_d = StFalha;
        end
      end
      StVeda: begin
        if (tmr_done) state_d = StConta;
      end
      StConta: begin
        if (garrafas_q == LastBottle) begin
          garrafas_d = '0;
          duzias_d   = duzias_q + 4'd1;
          state_d    = StCaixa;
        end else begin
          garrafas_d = garrafas_q + 4'd1;
          state_d    = STOP ? StIdle : StEsteira;
        end
      end
      StCaixa: begin
        // DUZIAS already holds the incremented count here.
        if (duzias_q == BatchBoxes) begin
          state_d = StLote;
        end else begin
          state_d = STOP ? StIdle : StEsteira;
        end
      end
      StLote: begin
        if (ACK_LOTE) begin
          duzias_d   = '0;
          garrafas_d = '0;
          state_d    = StIdle;
        end
      end
      StFalha: begin
`ifdef DESCARTE_EN
        state_d = StEsteira;
`else
        if (ACK_LOTE) state_d = StEsteira;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  // Timer: reload on entry to ENCHE/VEDA, held at zero everywhere else.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_clear = (state_d != StEnche) && (state_d != StVeda);
    if ((state_d == StEnche) && (state_q != StEnche)) begin
      tmr_load = 1'b1;
      tmr_val  = FillLoad;
    end else if ((state_d == StVeda) && (state_q != StVeda)) begin
      tmr_load = 1'b1;
      tmr_val  = CapLoad;
    end
  end

  // Outputs are a registered decode of the next state.
  always_comb begin
    motor_d   = (state_d == StEsteira);
    valvula_d = (state_d == StEnche);
    vedador_d = (state_d == StVeda);
    pulso_d   = (state_d == StCaixa);
    lote_d    = (state_d == StLote);
    alarme_d  = (state_d == StFalha);
  end

`ifdef DESCARTE_EN
  always_comb begin
    rejeita_d    = (state_d == StFalha);
    rejeitados_d = rejeitados_q;
    if ((state_d == StFalha) && (state_q != StFalha) && (rejeitados_q != 8'hFF)) begin
      rejeitados_d = rejeitados_q + 8'd1;
    end
  end
`endif

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q    <= StIdle;
      garrafas_q <= '0;
      duzias_q   <= '0;
      motor_q    <= 1'b0;
      valvula_q  <= 1'b0;
      vedador_q  <= 1'b0;
      pulso_q    <= 1'b0;
      lote_q     <= 1'b0;
      alarme_q   <= 1'b0;
`ifdef DESCARTE_EN
      rejeita_q    <= 1'b0;
      rejeitados_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      garrafas_q <= garrafas_d;
      duzias_q   <= duzias_d;
      motor_q    <= motor_d;
      valvula_q  <= valvula_d;
      vedador_q  <= vedador_d;
      pulso_q    <= pulso_d;
      lote_q     <= lote_d;
      alarme_q   <= alarme_d;
`ifdef DESCARTE_EN
      rejeita_q    <= rejeita_d;
      rejeitados_q <= rejeitados_d;
`endif
    end
  end

  assign MOTOR       = motor_q;
  assign VALVULA     = valvula_q;
  assign VEDADOR     = vedador_q;
  assign PULSO_DUZIA = pulso_q;
  assign LOTE_CHEIO  = lote_q;
  assign ALARME      = alarme_q;
  assign GARRAFAS    = garrafas_q;
  assign DUZIAS      = duzias_q;
  assign ESTADO      = state_q;
`ifdef DESCARTE_EN
  assign REJEITA     = rejeita_q;
  assign REJEITADOS  = rejeitados_q;
`endif

endmodule

// File: tb/tb_controle_envase.sv
// Randomized bench for controle_envase against a cycle-level reference model
// of the station (phase number plus plain integer counters).
module tb_controle_envase;

  localparam int FillTimeout   = 50;
  localparam int CapCycles     = 4;
  localparam int BottlesPerBox = 12;
  localparam int BoxesPerBatch = 10;
`ifdef DESCARTE_EN
  localparam bit Descarte = 1'b1;
`else
  localparam bit Descarte = 1'b0;
`endif

  // Station phases, numbered as shown on the ESTADO display.
  localparam int PIdle = 0, PEsteira = 1, PEnche = 2, PVeda = 3;
  localparam int PConta = 4, PCaixa = 5, PLote = 6, PFalha = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop, garrafa, nivel, ack;
  logic       motor, valvula, vedador, pulso, lote_cheio, alarme;
  logic [3:0] garrafas, duzias;
  logic [2:0] estado;
`ifdef DESCARTE_EN
  logic       rejeita;
  logic [7:0] rejeitados;
`endif

  controle_envase dut (
    .CLOCK          (clk),
    .RESET          (rst),
    .START          (start),
    .STOP           (stop),
    .SENSOR_GARRAFA (garrafa),
    .SENSOR_NIVEL   (nivel),
    .ACK_LOTE       (ack),
    .MOTOR          (motor),
    .VALVULA        (valvula),
    .VEDADOR        (vedador),
    .PULSO_DUZIA    (pulso),
    .LOTE_CHEIO     (lote_cheio),
    .ALARME         (alarme),
    .GARRAFAS       (garrafas),
    .DUZIAS         (duzias),
    .ESTADO         (estado)
`ifdef DESCARTE_EN
    ,
    .REJEITA        (rejeita),
    .REJEITADOS     (rejeitados)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model state.
  int m_phase = PIdle;
  int m_fill  = 0;   // cycles already spent filling
  int m_cap   = 0;   // cycles already spent capping
  int m_garr  = 0;
  int m_duz   = 0;
  int m_rej   = 0;

  task automatic model_step();
    if (rst) begin
      m_phase = PIdle; m_fill = 0; m_cap = 0; m_garr = 0; m_duz = 0; m_rej = 0;
      return;
    end
    case (m_phase)
      PIdle:    if (start && !stop) m_phase = PEsteira;
      PEsteira: begin
        if (stop) m_phase = PIdle;
        else if (garrafa) begin m_phase = PEnche; m_fill = 0; end
      end
      PEnche: begin
        if (nivel) begin
          m_phase = PVeda; m_cap = 0;
        end else if (m_fill == FillTimeout - 1) begin
          m_phase = PFalha;
          if (Descarte && m_rej < 255) m_rej++;
        end else m_fill++;
      end
      PVeda:    if (m_cap == CapCycles - 1) m_phase = PConta; else m_cap++;
      PConta: begin
        if (m_garr + 1 == BottlesPerBox) begin
          m_garr = 0; m_duz++; m_phase = PCaixa;
        end else begin
          m_garr++; m_phase = stop ? PIdle : PEsteira;
        end
      end
      PCaixa:   m_phase = (m_duz == BoxesPerBatch) ? PLote : (stop ? PIdle : PEsteira);
      PLote:    if (ack) begin m_duz = 0; m_garr = 0; m_phase = PIdle; end
      PFalha:   if (Descarte || ack) m_phase = PEsteira;
      default:  m_phase = PIdle;
    endcase
  endtask

  task automatic compare_all();
    check("estado", estado, m_phase);
    check("motor", motor, m_phase == PEsteira);
    check("valvula", valvula, m_phase == PEnche);
    check("vedador", vedador, m_phase == PVeda);
    check("pulso_duzia", pulso, m_phase == PCaixa);
    check("lote_cheio", lote_cheio, m_phase == PLote);
    check("alarme", alarme, m_phase == PFalha);
    check("garrafas", garrafas, m_garr);
    check("duzias", duzias, m_duz);
    check("one_actuator", (32'(motor) + 32'(valvula) + 32'(vedador)) <= 1, 1);
`ifdef DESCARTE_EN
    check("rejeita", rejeita, m_phase == PFalha);
    check("rejeitados", rejeitados, m_rej);
`endif
  endtask

  function automatic logic chance(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  typedef struct {
    int cycles;
    int p_start, p_stop, p_garr, p_niv, p_ack, p_rst;
  } seg_t;

  seg_t segs [5];

  initial begin
    // cycles, start, stop, garrafa, nivel, ack, reset (percent per cycle)
    segs[0] = '{60,   100, 0, 30, 20, 0,  0};  // plain bottles from reset
    segs[1] = '{2500, 60,  2, 50, 40, 5,  0};  // boxes, batch full, stops
    segs[2] = '{600,  80,  1, 50, 1,  3,  0};  // fill timeouts
    segs[3] = '{1500, 50,  5, 40, 25, 10, 1};  // resets in arbitrary phases
    segs[4] = '{2500, 90,  0, 80, 60, 2,  0};  // long batch-full holds with START

    rst = 1'b1; start = 1'b0; stop = 1'b0; garrafa = 1'b0; nivel = 1'b0; ack = 1'b0;
    repeat (2) begin
      @(posedge clk);
      model_step();
      #1 compare_all();
    end

    foreach (segs[s]) begin
      for (int c = 0; c < segs[s].cycles; c++) begin
        @(negedge clk);
        rst     = chance(segs[s].p_rst);
        start   = chance(segs[s].p_start);
        stop    = chance(segs[s].p_stop);
        garrafa = chance(segs[s].p_garr);
        nivel   = chance(segs[s].p_niv);
        ack     = chance(segs[s].p_ack);
        @(posedge clk);
        model_step();
        #1 compare_all();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
